// File: rtl/sm_uart_pkg.sv
// Shared constants for the external-output UART transmitter:
// FSM state encoding and 8N1 frame shape.
package sm_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int   DATA_BITS = 8;
    localparam int   STOP_BITS = 1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sm_ext_uart_tx_if.sv
// CPU-side bundle of the external-output UART: the watched register value
// in, serial line and status out.
interface sm_ext_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   extOut;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] level;

    modport master (output extOut, input tx, busy, overflow, level);
    modport slave  (input extOut, output tx, busy, overflow, level);

endinterface

// File: rtl/sm_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit
// so a full queue and an empty queue are told apart.
module sm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A full queue still accepts a push when the same edge pops a slot free.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout  = mem[rptr[AW-1:0]];
    assign level = count;

    // NOTE: storage has no reset; the pointers alone decide what is valid,
    // which keeps the array as plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sm_ext_uart_tx.sv
// Turns every change of the CPU external output register into one queued
// byte and streams the queue out as contiguous 8N1 frames.
module sm_ext_uart_tx
    import sm_uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    sm_ext_uart_tx_if.slave  bus
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      prev;
    logic             push_req;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [LW-1:0]    fifo_level;
    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_last;
    logic             stop_last;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_q;
    logic             overflow_q;

    // Upper bits only matter for spotting a new write; the byte is bits 7:0.
    assign push_req  = (bus.extOut != prev);
    assign baud_last = (baud_cnt == CNT_W'(CLK_DIV - 1));
    assign stop_last = baud_last && (bit_idx == 3'(STOP_BITS - 1));
    assign fifo_pop  = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && stop_last));

    sm_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .din   (bus.extOut[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev       <= bus.extOut;
            overflow_q <= overflow_q | (push_req & fifo_full & ~fifo_pop);
        end
    end

    // tx is updated on the same edge as the state so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= LINE_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shift <= fifo_dout;
                        state <= ST_START;
                        tx_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx_q     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                            tx_q    <= LINE_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (stop_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        // Chain straight into the next start bit when more bytes wait.
                        if (fifo_pop) begin
                            shift <= fifo_dout;
                            state <= ST_START;
                            tx_q  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx_q  <= LINE_IDLE;
                        end
                    end else if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= LINE_IDLE;
                end
            endcase
        end
    end

    assign bus.tx       = tx_q;
    assign bus.overflow = overflow_q;
    assign bus.level    = fifo_level;
    assign bus.busy     = (state != ST_IDLE) || (fifo_level != '0);

endmodule
